gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
- Built-in self-test sequencer for the basic_gates block (AND/OR/NOT-a/NAND/NOR/XOR/XNOR on inputs a, b).
- On a start request it drives the four input vectors 00, 01, 10, 11 into the gate block, waits a settle interval, and samples all seven gate outputs.
- It checks each sample against the truth table and reports per-vector and per-gate failure masks, a saturating error count and a pass flag.
- It sits between the gate block and a test/status interface.

Parameters:
SETTLE_CYCLES, 2, cycles a,b are held before sampling; legal range 1..15.
PASSES, 1, full 4-vector sweeps per run; legal range 1..255.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  run request, sampled only in IDLE.
abort  input  1  cancel current run.
a  output  1  gate-block input a (registered).
b  output  1  gate-block input b (registered).
g_and, g_or, g_not_a, g_nand, g_nor, g_xor, g_xnor  input  1 each  gate-block outputs.
busy  output  1  run in progress.
done  output  1  one-cycle pulse at normal completion.
pass  output  1  1 if last completed run had zero errors.
fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched in any pass.
fail_gates  output  7  OR of mismatch masks; bit order [0]and [1]or [2]not_a [3]nand [4]nor [5]xor [6]xnor.
err_count  output  8  count of mismatching vector checks, saturating at 255.

Behaviour:
Reset:
- rst=1 at an edge forces state IDLE.
- Outputs after reset: a=0, b=0, busy=0, done=0, pass=0, fail_vec=0, fail_gates=0, err_count=0.
- rst has priority over abort and start.

States and transitions:
- IDLE: a,b=00, busy=0. start=1 → APPLY with vector index 0 and pass counter 0; clears fail_vec, fail_gates, err_count and pass in the same edge.
- APPLY: one cycle. Registers {a,b}=index. Loads settle counter with SETTLE_CYCLES−1. Goes to WAIT.
- WAIT: stays while the counter is nonzero, decrementing each cycle. Occupies exactly SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK: one cycle.
  - Computes expected outputs from the held a,b: and=a&b, or=a|b, not_a=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
  - mask = expected XOR sampled inputs.
  - If mask≠0: fail_vec[index] set, fail_gates |= mask, err_count += 1 (saturating at 255).
  - Index wraps 3→0 and the pass counter increments at each wrap.
  - If index=3 and pass counter=PASSES−1 → DONE, otherwise → APPLY.
- DONE: one cycle. done=1, busy=0. pass=1 iff err_count==0 (fail state includes the final CHECK update). Goes to IDLE.

Timing and outputs:
- busy=1 in APPLY, WAIT and CHECK.
- Each vector occupies SETTLE_CYCLES+2 cycles.
- If start is sampled at edge k, busy is high for cycles k+1 .. k+4·PASSES·(S+2), and done is high in cycle k+1+4·PASSES·(S+2).
- a,b change only on entry to APPLY and on return to IDLE (back to 00).

Boundary conditions:
- start while busy or in DONE: ignored; no queuing.
- start held high continuously: a new run begins at the first IDLE cycle, so there is one IDLE cycle between runs.
- abort=1 in APPLY, WAIT or CHECK: next state IDLE, no done pulse, pass=0. fail_vec, fail_gates and err_count keep their partial values. An abort in CHECK still applies that cycle's compare.
- abort in IDLE or DONE: no effect; DONE still pulses.
- Simultaneous start and abort in IDLE: start wins.
- err_count saturates at 255 and does not wrap. fail masks remain sticky until the next start.

Test Plan:
1. Fault-free gate block, S=2, P=1, start pulse at edge 0 → busy high cycles 1–16; {a,b} = 00, 01, 10, 11 each held 4 cycles; done high at cycle 17 only; pass=1, err_count=0, fail_vec=0000, fail_gates=0000000.
2. g_xor tied 0, S=2, P=1 → fail_vec=0110, fail_gates=0100000, err_count=2, pass=0, done at cycle 17.
3. g_not_a inverted, S=1, P=3 → err_count=12, fail_vec=1111, fail_gates=0000100, done at cycle 37 (1+12·3).
4. Extra start pulses at cycles 5 and 17, plus start held high after done → no run restart mid-sweep; exactly one done per run; the next run's busy rises two cycles after done.
5. abort at cycle 6 of a S=2 run → IDLE at cycle 7, busy=0, a=b=0, no done, pass=0. Separately, rst at cycle 10 → all outputs at reset values next cycle.
6. All seven g_* inverted, S=1, P=70 → 280 failing checks; err_count=255 (saturated, no wrap), fail_gates=1111111, pass=0.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
//   Built-in self-test sequencer for the basic_gates block. A run applies
//   the vectors {a,b} = 00, 01, 10, 11 in turn. Each vector is held for a
//   settle interval, then all seven gate outputs are sampled and compared
//   against the truth table. A run repeats the 4-vector sweep PASSES times.
//
// Parameters
//   SETTLE_CYCLES  cycles a,b are held before sampling (1..15)
//   PASSES         full 4-vector sweeps per run (1..255)
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        run request, only looked at in IDLE
//   i_abort        cancel the run in progress (APPLY/WAIT/CHECK only)
//   o_a, o_b       registered stimulus to the gate block
//   i_g_*          the seven gate-block outputs
//   o_busy         run in progress (APPLY, WAIT, CHECK)
//   o_done         one-cycle pulse on normal completion
//   o_pass         last completed run had zero mismatches
//   o_fail_vec     bit i set if vector {a,b}=i mismatched in any sweep
//   o_fail_gates   sticky OR of mismatch masks
//                  [0]and [1]or [2]not_a [3]nand [4]nor [5]xor [6]xnor
//   o_err_count    number of mismatching vector checks, saturating at 255
// -----------------------------------------------------------------------------
module gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_a,
  output logic       o_b,
  input  logic       i_g_and,
  input  logic       i_g_or,
  input  logic       i_g_not_a,
  input  logic       i_g_nand,
  input  logic       i_g_nor,
  input  logic       i_g_xor,
  input  logic       i_g_xnor,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_vec,
  output logic [6:0] o_fail_gates,
  output logic [7:0] o_err_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // The settle counter counts SETTLE_CYCLES-1 .. 0, so WAIT lasts exactly
  // SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

  state_t     r_state;
  state_t     w_state_next;

  logic [1:0] r_idx;
  logic [7:0] r_pass_cnt;
  logic [3:0] r_settle;
  logic       r_a;
  logic       r_b;
  logic       r_pass;
  logic [3:0] r_fail_vec;
  logic [6:0] r_fail_gates;
  logic [7:0] r_err_count;

  logic [6:0] w_sampled;
  logic [6:0] w_expected;
  logic [6:0] w_mask;
  logic       w_mismatch;
  logic [3:0] w_vec_hit;
  logic [7:0] w_err_next;
  logic [1:0] w_idx_next;
  logic       w_last_vec;
  logic       w_last_pass;
  logic       w_abort_run;

  // ---------------------------------------------------------------------------
  // Compare datapath: expected values come from the held a,b registers, so
  // the comparison is against exactly what the gate block has been seeing.
  // ---------------------------------------------------------------------------
  assign w_sampled  = {i_g_xnor, i_g_xor, i_g_nor, i_g_nand,
                       i_g_not_a, i_g_or, i_g_and};
  assign w_expected = {~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b), ~(r_a & r_b),
                       ~r_a, r_a | r_b, r_a & r_b};
  assign w_mask     = w_expected ^ w_sampled;
  assign w_mismatch = |w_mask;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_vec_hit
      assign w_vec_hit[gi] = w_mismatch && (r_idx == 2'(gi));
    end
  endgenerate

  assign w_err_next  = (w_mismatch && (r_err_count != 8'hFF)) ?
                       r_err_count + 8'd1 : r_err_count;
  assign w_last_vec  = (r_idx == 2'd3);
  assign w_last_pass = (r_pass_cnt == LAST_PASS);
  // Index of the vector about to be applied; only meaningful on APPLY entry.
  assign w_idx_next  = (r_state == ST_CHECK) ? r_idx + 2'd1 : 2'd0;
  assign w_abort_run = i_abort && ((r_state == ST_APPLY) ||
                                   (r_state == ST_WAIT)  ||
                                   (r_state == ST_CHECK));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_APPLY;
      end
      ST_APPLY: begin
        o_busy = 1'b1;
        if (i_abort) w_state_next = ST_IDLE;
        else         w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        o_busy = 1'b1;
        if (i_abort)              w_state_next = ST_IDLE;
        else if (r_settle == 4'd0) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        o_busy = 1'b1;
        if (i_abort)                       w_state_next = ST_IDLE;
        else if (w_last_vec && w_last_pass) w_state_next = ST_DONE;
        else                               w_state_next = ST_APPLY;
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencing counters, stimulus and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx        <= 2'd0;
      r_pass_cnt   <= 8'd0;
      r_settle     <= 4'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_vec   <= 4'd0;
      r_fail_gates <= 7'd0;
      r_err_count  <= 8'd0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_idx        <= 2'd0;
        r_pass_cnt   <= 8'd0;
        r_pass       <= 1'b0;
        r_fail_vec   <= 4'd0;
        r_fail_gates <= 7'd0;
        r_err_count  <= 8'd0;
      end

      if (r_state == ST_APPLY) begin
        r_settle <= SETTLE_LOAD;
      end

      if ((r_state == ST_WAIT) && (r_settle != 4'd0)) begin
        r_settle <= r_settle - 4'd1;
      end

      // The compare is committed even when abort arrives in the same cycle.
      if (r_state == ST_CHECK) begin
        r_fail_vec   <= r_fail_vec | w_vec_hit;
        r_fail_gates <= r_fail_gates | w_mask;
        r_err_count  <= w_err_next;
        r_idx        <= r_idx + 2'd1;
        if (w_last_vec) r_pass_cnt <= r_pass_cnt + 8'd1;
      end

      // Verdict uses the count including the final check of the run.
      if ((r_state == ST_CHECK) && (w_state_next == ST_DONE)) begin
        r_pass <= (w_err_next == 8'd0);
      end else if (w_abort_run) begin
        r_pass <= 1'b0;
      end

      // a,b move only when a vector is applied or the sequencer goes idle.
      if (w_state_next == ST_APPLY) begin
        {r_a, r_b} <= w_idx_next;
      end else if ((w_state_next == ST_IDLE) && (r_state != ST_IDLE)) begin
        {r_a, r_b} <= 2'b00;
      end
    end
  end

  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_pass       = r_pass;
  assign o_fail_vec   = r_fail_vec;
  assign o_fail_gates = r_fail_gates;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_ctrl
//   Three controller instances with different settle/pass settings, each
//   driving its own behavioural gate block whose outputs can be corrupted per
//   vector through an inversion table. Expected results are derived from the
//   truth table, the inversion table and the run timing arithmetic.
//   Instance 0: S=2 P=1, instance 1: S=1 P=3, instance 2: S=1 P=70.
// -----------------------------------------------------------------------------
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_r [3];
  logic       abort_r [3];
  logic       a_w     [3];
  logic       b_w     [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic [3:0] fv_w    [3];
  logic [6:0] fg_w    [3];
  logic [7:0] ec_w    [3];
  logic [6:0] gates_w [3];
  logic [6:0] inv_tab [3][4];

  int checks = 0;
  int errors = 0;

  // Truth table per vector {a,b}; bits {xnor,xor,nor,nand,not_a,or,and}.
  function automatic logic [6:0] truth(input int v);
    case (v)
      0:       return 7'b1011100;
      1:       return 7'b0101110;
      2:       return 7'b0101010;
      default: return 7'b1000011;
    endcase
  endfunction

  function automatic int s_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int p_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 70;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      assign gates_w[gi] = truth(int'({a_w[gi], b_w[gi]})) ^
                           inv_tab[gi][{a_w[gi], b_w[gi]}];
      gate_bist_ctrl #(
        .SETTLE_CYCLES(s_of(gi)),
        .PASSES       (p_of(gi))
      ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start_r[gi]),
        .i_abort     (abort_r[gi]),
        .o_a         (a_w[gi]),
        .o_b         (b_w[gi]),
        .i_g_and     (gates_w[gi][0]),
        .i_g_or      (gates_w[gi][1]),
        .i_g_not_a   (gates_w[gi][2]),
        .i_g_nand    (gates_w[gi][3]),
        .i_g_nor     (gates_w[gi][4]),
        .i_g_xor     (gates_w[gi][5]),
        .i_g_xnor    (gates_w[gi][6]),
        .o_busy      (busy_w[gi]),
        .o_done      (done_w[gi]),
        .o_pass      (pass_w[gi]),
        .o_fail_vec  (fv_w[gi]),
        .o_fail_gates(fg_w[gi]),
        .o_err_count (ec_w[gi])
      );
    end
  endgenerate

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_r[d] = 1'b0;
      abort_r[d] = 1'b0;
      for (int v = 0; v < 4; v++) inv_tab[d][v] = 7'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({a_w[d], b_w[d], busy_w[d], done_w[d], pass_w[d],
           fv_w[d], fg_w[d], ec_w[d]} !== 24'd0) begin
        errors++;
        $display("FAIL reset d=%0d: got ab=%b%b busy=%b done=%b pass=%b fv=%b fg=%b ec=%0d expected all zero",
                 d, a_w[d], b_w[d], busy_w[d], done_w[d], pass_w[d], fv_w[d], fg_w[d], ec_w[d]);
      end
    end
    rst = 1'b0;
    $display("reset: outputs checked on 3 instances");
  endtask

  // Full run with cycle-by-cycle timing checks and final result checks.
  // ab0: abort raised together with start in IDLE; abdone: abort in DONE.
  task automatic run_check(input int d, input bit ab0, input bit abdone,
                           input string name);
    int         s, p, tot, nfail, eerr, ndone;
    logic [3:0] efv;
    logic [6:0] efg;
    logic       epass, eb, edn;
    logic [1:0] eab;
    s = s_of(d);
    p = p_of(d);
    tot = 4 * p * (s + 2);
    nfail = 0;
    efv = 4'd0;
    efg = 7'd0;
    for (int v = 0; v < 4; v++) begin
      if (inv_tab[d][v] != 7'd0) begin
        efv[v] = 1'b1;
        efg    = efg | inv_tab[d][v];
        nfail++;
      end
    end
    eerr  = (nfail * p > 255) ? 255 : nfail * p;
    epass = (eerr == 0);
    ndone = 0;

    @(negedge clk);
    start_r[d] = 1'b1;
    abort_r[d] = ab0;
    for (int t = 1; t <= tot + 2; t++) begin
      @(negedge clk);
      start_r[d] = 1'b0;
      abort_r[d] = 1'b0;
      eb  = (t <= tot);
      edn = (t == tot + 1);
      if (t <= tot)        eab = 2'(((t - 1) / (s + 2)) % 4);
      else if (t == tot + 1) eab = 2'b11;
      else                 eab = 2'b00;
      if (done_w[d] === 1'b1) ndone++;
      checks++;
      if (busy_w[d] !== eb) begin
        errors++;
        $display("FAIL %s busy t=%0d: got %b expected %b", name, t, busy_w[d], eb);
      end
      checks++;
      if (done_w[d] !== edn) begin
        errors++;
        $display("FAIL %s done t=%0d: got %b expected %b", name, t, done_w[d], edn);
      end
      checks++;
      if ({a_w[d], b_w[d]} !== eab) begin
        errors++;
        $display("FAIL %s ab t=%0d: got %b%b expected %b", name, t, a_w[d], b_w[d], eab);
      end
      if (t == 1) begin
        checks++;
        if ({pass_w[d], fv_w[d], fg_w[d], ec_w[d]} !== 20'd0) begin
          errors++;
          $display("FAIL %s cleared_at_start: got pass=%b fv=%b fg=%b ec=%0d expected zeros",
                   name, pass_w[d], fv_w[d], fg_w[d], ec_w[d]);
        end
      end
      if (t >= tot + 1) begin
        checks++;
        if (pass_w[d] !== epass) begin
          errors++;
          $display("FAIL %s pass t=%0d: got %b expected %b", name, t, pass_w[d], epass);
        end
        checks++;
        if (fv_w[d] !== efv) begin
          errors++;
          $display("FAIL %s fail_vec t=%0d: got %b expected %b", name, t, fv_w[d], efv);
        end
        checks++;
        if (fg_w[d] !== efg) begin
          errors++;
          $display("FAIL %s fail_gates t=%0d: got %b expected %b", name, t, fg_w[d], efg);
        end
        checks++;
        if (ec_w[d] !== 8'(eerr)) begin
          errors++;
          $display("FAIL %s err_count t=%0d: got %0d expected %0d", name, t, ec_w[d], eerr);
        end
      end
      if (abdone && (t == tot + 1)) abort_r[d] = 1'b1;
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", name, ndone);
    end
    $display("run %s d=%0d S=%0d P=%0d: err_count=%0d fail_vec=%b fail_gates=%b pass=%b",
             name, d, s, p, ec_w[d], fv_w[d], fg_w[d], pass_w[d]);
  endtask

  task automatic test_clean();
    for (int v = 0; v < 4; v++) inv_tab[0][v] = 7'd0;
    run_check(0, 1'b0, 1'b0, "clean");
  endtask

  task automatic test_xor_stuck0();
    for (int v = 0; v < 4; v++) inv_tab[0][v] = truth(v) & 7'b0100000;
    run_check(0, 1'b0, 1'b0, "xor_stuck0");
  endtask

  task automatic test_not_a_inverted();
    for (int v = 0; v < 4; v++) inv_tab[1][v] = 7'b0000100;
    run_check(1, 1'b0, 1'b0, "not_a_inv");
  endtask

  task automatic test_saturate();
    for (int v = 0; v < 4; v++) inv_tab[2][v] = 7'h7F;
    run_check(2, 1'b0, 1'b0, "saturate");
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 1));
      for (int v = 0; v < 4; v++)
        inv_tab[d][v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
      run_check(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  // Extra starts mid-run and in DONE are ignored; start held after DONE
  // launches the next run with one IDLE cycle in between.
  task automatic test_back_to_back();
    logic eb, edn;
    int   ndone;
    for (int v = 0; v < 4; v++) inv_tab[0][v] = 7'd0;
    ndone = 0;
    @(negedge clk);
    start_r[0] = 1'b1;
    for (int t = 1; t <= 37; t++) begin
      @(negedge clk);
      eb  = ((t >= 1) && (t <= 16)) || ((t >= 19) && (t <= 34));
      edn = (t == 17) || (t == 35);
      if (done_w[0] === 1'b1) ndone++;
      checks++;
      if (busy_w[0] !== eb) begin
        errors++;
        $display("FAIL b2b busy t=%0d: got %b expected %b", t, busy_w[0], eb);
      end
      checks++;
      if (done_w[0] !== edn) begin
        errors++;
        $display("FAIL b2b done t=%0d: got %b expected %b", t, done_w[0], edn);
      end
      start_r[0] = (t == 5) || ((t >= 17) && (t <= 20));
    end
    start_r[0] = 1'b0;
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL b2b done_count: got %0d expected 2", ndone);
    end
    checks++;
    if (pass_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b pass: got %b expected 1", pass_w[0]);
    end
    $display("back_to_back: %0d done pulses over two runs", ndone);
  endtask

  // Abort raised during cycle ta of an S=2 P=1 run; checks completed before
  // the abort (including one in the abort cycle) keep their effect.
  task automatic abort_run(input int ta);
    int         nchk, eerr;
    logic [3:0] efv;
    logic [6:0] efg;
    int         ndone;
    nchk  = ta / 4;
    eerr  = 0;
    efv   = 4'd0;
    efg   = 7'd0;
    ndone = 0;
    for (int v = 0; v < nchk; v++) begin
      if (inv_tab[0][v] != 7'd0) begin
        efv[v] = 1'b1;
        efg    = efg | inv_tab[0][v];
        eerr++;
      end
    end
    @(negedge clk);
    start_r[0] = 1'b1;
    for (int t = 1; t <= ta + 4; t++) begin
      @(negedge clk);
      start_r[0] = 1'b0;
      abort_r[0] = 1'b0;
      if (done_w[0] === 1'b1) ndone++;
      checks++;
      if (busy_w[0] !== (t <= ta)) begin
        errors++;
        $display("FAIL abort%0d busy t=%0d: got %b expected %b", ta, t, busy_w[0], (t <= ta));
      end
      if (t > ta) begin
        checks++;
        if ({a_w[0], b_w[0], pass_w[0]} !== 3'b000) begin
          errors++;
          $display("FAIL abort%0d idle t=%0d: got ab=%b%b pass=%b expected 000",
                   ta, t, a_w[0], b_w[0], pass_w[0]);
        end
        checks++;
        if ({fv_w[0], fg_w[0], ec_w[0]} !== {efv, efg, 8'(eerr)}) begin
          errors++;
          $display("FAIL abort%0d partial t=%0d: got fv=%b fg=%b ec=%0d expected fv=%b fg=%b ec=%0d",
                   ta, t, fv_w[0], fg_w[0], ec_w[0], efv, efg, eerr);
        end
      end
      if (t == ta) abort_r[0] = 1'b1;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort%0d done_count: got %0d expected 0", ta, ndone);
    end
    $display("abort at t=%0d: err_count=%0d fail_vec=%b", ta, ec_w[0], fv_w[0]);
  endtask

  task automatic test_abort();
    inv_tab[0][0] = 7'($urandom_range(1, 127));
    for (int v = 1; v < 4; v++) inv_tab[0][v] = 7'($urandom);
    abort_run(6);
    abort_run(4);
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 4; v++)
        inv_tab[0][v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
      abort_run(int'($urandom_range(1, 16)));
    end
  endtask

  task automatic test_reset_midrun();
    for (int v = 0; v < 4; v++) inv_tab[0][v] = 7'h7F;
    @(negedge clk);
    start_r[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start_r[0] = 1'b0;
    end
    rst        = 1'b1;
    start_r[0] = 1'b1;
    abort_r[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0],
         fv_w[0], fg_w[0], ec_w[0]} !== 24'd0) begin
      errors++;
      $display("FAIL reset_midrun: got ab=%b%b busy=%b done=%b pass=%b fv=%b fg=%b ec=%0d expected all zero",
               a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], fv_w[0], fg_w[0], ec_w[0]);
    end
    rst        = 1'b0;
    start_r[0] = 1'b0;
    abort_r[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun idle: got busy=%b expected 0", busy_w[0]);
    end
    $display("reset_midrun: outputs checked after reset at t=10");
  endtask

  initial begin
    test_reset();
    test_clean();
    test_xor_stuck0();
    test_not_a_inverted();
    test_saturate();
    test_clean();
    test_back_to_back();
    test_clean();
    test_abort();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
